// File: rtl/axi4_pkg.sv
// Shared types and constants for the AXI4 slave write engine.
// Holds the burst/response/state enums, fixed AXI field widths and a helper
// that validates WRAP burst lengths.
package axi4_pkg;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  typedef enum logic [BURST_W-1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi4_burst_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi4_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_RESP = 2'b10
  } wr_state_e;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
    logic ok;
    case (len)
      8'd1, 8'd3, 8'd7, 8'd15: ok = 1'b1;
      default:                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/axi4_slave_wr_engine_if.sv
// AXI4 write-channel bundle (AW, W, B) between a master and the slave write
// engine.
//   master modport: drives AW*/W*/BREADY, observes AWREADY/WREADY/B*.
//   slave  modport: the reverse.
interface axi4_slave_wr_engine_if
  import axi4_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [LEN_W-1:0]    AWLEN;
  logic [SIZE_W-1:0]   AWSIZE;
  logic [BURST_W-1:0]  AWBURST;
  logic                AWVALID;
  logic                AWREADY;

  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;

  logic [ID_W-1:0]     BID;
  logic [RESP_W-1:0]   BRESP;
  logic                BVALID;
  logic                BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output WDATA, WSTRB, WLAST, WVALID,
    output BREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  WDATA, WSTRB, WLAST, WVALID,
    input  BREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID
  );

endinterface

// File: rtl/axi4_sync_fifo.sv
// Single-clock FIFO used to queue write-address requests.
// Ports: clk/rst (async active-high), push_i/wdata_i write side,
// pop_i/rdata_o read side (rdata_o shows the head entry, first-word
// fall-through), full_o/empty_o status. Push while full and pop while empty
// are ignored; full blocks a push even when a pop happens in the same cycle.
module axi4_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/axi4_slave_wr_engine.sv
// AXI4 slave write engine: queues AW requests, accepts W beats for one burst
// at a time, drives a synchronous memory write port and returns one B
// response per burst.
// Ports: ACLK/ARESET (async active-high); axi (slave modport, AW/W/B
// channels); mem_we/mem_addr/mem_wdata/mem_wstrb registered memory write
// port, valid the cycle after each accepted W beat.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for a queued address; pops and latches it
// ST_DATA | WREADY high, one memory write per accepted beat
// ST_RESP | BVALID high with BID/BRESP held until BREADY
module axi4_slave_wr_engine
  import axi4_pkg::*;
#(
  parameter int ID_W     = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int AW_DEPTH = 4
) (
  input  logic                ACLK,
  input  logic                ARESET,
  axi4_slave_wr_engine_if.slave axi,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb
);

  localparam int STRB_W = DATA_W / 8;
  localparam int AW_W   = ID_W + ADDR_W + LEN_W + SIZE_W + BURST_W;
  localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'($clog2(STRB_W));

  // AW queue
  logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [AW_W-1:0]   fifo_wdata, fifo_rdata;
  logic [ID_W-1:0]   f_id;
  logic [ADDR_W-1:0] f_addr;
  logic [LEN_W-1:0]  f_len;
  logic [SIZE_W-1:0] f_size;
  logic [BURST_W-1:0] f_burst;
  logic              f_illegal;

  assign axi.AWREADY = !fifo_full && !ARESET;
  assign fifo_push   = axi.AWVALID && axi.AWREADY;
  assign fifo_wdata  = {axi.AWID, axi.AWADDR, axi.AWLEN, axi.AWSIZE, axi.AWBURST};
  assign {f_id, f_addr, f_len, f_size, f_burst} = fifo_rdata;

  axi4_sync_fifo #(.WIDTH(AW_W), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .clk     (ACLK),
    .rst     (ARESET),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Errors detectable from the address alone also suppress every write.
  assign f_illegal = (f_burst == BURST_RSVD) || (f_size > MAX_SIZE) ||
                     ((f_burst == BURST_WRAP) && !wrap_len_ok(f_len));

  // Burst context
  wr_state_e         state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [SIZE_W-1:0] size_q, size_d;
  axi4_burst_e       burst_q, burst_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              err_q, err_d;
  logic              supp_q, supp_d;

  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;

  logic w_ready, b_valid, beat_last;

  // Address generator. WRAP keeps the bits above the wrap window and lets
  // the offset inside the window roll over; carries out of ADDR_W are lost.
  logic [ADDR_W-1:0] step, addr_inc, wrap_mask, addr_next;

  always_comb begin
    step      = ADDR_W'(1) << size_q;
    addr_inc  = addr_q + step;
    wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
    case (burst_q)
      BURST_FIXED: addr_next = addr_q;
      BURST_WRAP:  addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default:     addr_next = addr_inc;
    endcase
  end

  assign beat_last = (beat_q == len_q);

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    beat_d      = beat_q;
    err_d       = err_q;
    supp_d      = supp_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    fifo_pop    = 1'b0;
    w_ready     = 1'b0;
    b_valid     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          id_d     = f_id;
          addr_d   = f_addr;
          len_d    = f_len;
          size_d   = f_size;
          burst_d  = axi4_burst_e'(f_burst);
          beat_d   = '0;
          err_d    = f_illegal;
          supp_d   = f_illegal;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        w_ready = 1'b1;
        if (axi.WVALID) begin
          mem_we_d    = !supp_q;
          mem_addr_d  = addr_q;
          mem_wdata_d = axi.WDATA;
          mem_wstrb_d = axi.WSTRB;
          addr_d      = addr_next;
          beat_d      = beat_q + 1'b1;
          // Beat count follows AWLEN; a misplaced WLAST only flags the error.
          if (axi.WLAST != beat_last) err_d = 1'b1;
          if (beat_last) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        b_valid = 1'b1;
        if (axi.BREADY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= BURST_FIXED;
      beat_q      <= '0;
      err_q       <= 1'b0;
      supp_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      supp_q      <= supp_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign axi.WREADY = w_ready;
  assign axi.BVALID = b_valid;
  assign axi.BID    = id_q;
  assign axi.BRESP  = (b_valid && err_q) ? RESP_SLVERR : RESP_OKAY;

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_axi4_slave_wr_engine.sv
// Directed bench for axi4_slave_wr_engine: a burst table plus hand-written
// sequences for queueing, B back-pressure and reset in mid-burst.
module tb_axi4_slave_wr_engine;
  import axi4_pkg::*;

  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, AW_DEPTH = 4;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  axi4_slave_wr_engine_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi();

  axi4_slave_wr_engine #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AW_DEPTH(AW_DEPTH)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .axi       (axi),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] s; } wr_t;
  wr_t wq[$];

  always @(negedge ACLK) begin
    if (mem_we === 1'b1) wq.push_back('{mem_addr, mem_wdata, mem_wstrb});
  end

  typedef struct {
    logic [3:0]       id;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    int               wl;
    int               nwr;
    logic [3:0][31:0] ea;
    logic [1:0]       resp;
  } vec_t;

  vec_t vt[11];

  function automatic vec_t mk(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input int size, input logic [1:0] burst, input int wl, input int nwr,
                              input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                              input logic [31:0] a3, input logic [1:0] resp);
    vec_t v;
    v.id = id; v.addr = addr; v.len = 8'(len); v.size = 3'(size); v.burst = burst;
    v.wl = wl; v.nwr = nwr; v.ea = {a3, a2, a1, a0}; v.resp = resp;
    return v;
  endfunction

  function automatic logic [31:0] wd(input logic [3:0] id, input int beat);
    return {4'h0, id, 8'h5A, 8'(beat), 8'hC3};
  endfunction

  function automatic logic [3:0] ws(input int beat);
    return 4'(beat + 1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for handshake", nm);
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input int size, input logic [1:0] burst);
    bit ok;
    @(negedge ACLK);
    axi.AWID = id; axi.AWADDR = addr; axi.AWLEN = 8'(len);
    axi.AWSIZE = 3'(size); axi.AWBURST = burst; axi.AWVALID = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (axi.AWREADY) begin
        @(posedge ACLK);
        ok = 1'b1;
        break;
      end
      @(negedge ACLK);
    end
    #1 axi.AWVALID = 1'b0;
    if (!ok) timeout("aw_handshake");
  endtask

  task automatic send_w(input logic [3:0] id, input int nbeats, input int wl_beat);
    bit ok;
    for (int b = 0; b < nbeats; b++) begin
      @(negedge ACLK);
      axi.WDATA = wd(id, b); axi.WSTRB = ws(b);
      axi.WLAST = (b == wl_beat); axi.WVALID = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 100; n++) begin
        if (axi.WREADY) begin
          @(posedge ACLK);
          ok = 1'b1;
          break;
        end
        @(negedge ACLK);
      end
      #1 axi.WVALID = 1'b0; axi.WLAST = 1'b0;
      if (!ok) begin
        timeout("w_handshake");
        break;
      end
    end
  endtask

  task automatic recv_b(input logic [3:0] exp_id, input logic [1:0] exp_resp);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge ACLK);
      if (axi.BVALID) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("b_valid");
    else begin
      chk("bid", axi.BID, exp_id);
      chk("bresp", axi.BRESP, exp_resp);
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic check_writes(input logic [3:0] id, input int n, input logic [3:0][31:0] ea);
    chk("wr_count", wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++) begin
      chk("wr_addr", wq[i].a, ea[i]);
      chk("wr_data", wq[i].d, wd(id, i));
      chk("wr_strb", wq[i].s, ws(i));
    end
    wq.delete();
  endtask

  initial begin
    axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = '0; axi.AWBURST = '0;
    axi.AWVALID = 1'b0; axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0;
    axi.WVALID = 1'b0; axi.BREADY = 1'b1;

    vt[0]  = mk(4'h3, 32'h0000_0100, 0, 2, 2'b01, 0, 1, 32'h100, 0, 0, 0, 2'b00);
    vt[1]  = mk(4'h1, 32'h0000_1000, 3, 2, 2'b01, 3, 4, 32'h1000, 32'h1004, 32'h1008, 32'h100C, 2'b00);
    vt[2]  = mk(4'h2, 32'h0000_2038, 3, 2, 2'b10, 3, 4, 32'h2038, 32'h203C, 32'h2030, 32'h2034, 2'b00);
    vt[3]  = mk(4'h4, 32'h0000_0300, 2, 2, 2'b00, 2, 3, 32'h300, 32'h300, 32'h300, 0, 2'b00);
    vt[4]  = mk(4'h5, 32'h0000_0400, 3, 2, 2'b01, 1, 4, 32'h400, 32'h404, 32'h408, 32'h40C, 2'b10);
    vt[5]  = mk(4'h6, 32'h0000_0440, 1, 2, 2'b11, 1, 0, 0, 0, 0, 0, 2'b10);
    vt[6]  = mk(4'h7, 32'h0000_0480, 0, 3, 2'b01, 0, 0, 0, 0, 0, 0, 2'b10);
    vt[7]  = mk(4'h8, 32'h0000_04C0, 2, 2, 2'b10, 2, 0, 0, 0, 0, 0, 2'b10);
    vt[8]  = mk(4'h9, 32'h0000_0501, 3, 0, 2'b01, 3, 4, 32'h501, 32'h502, 32'h503, 32'h504, 2'b00);
    vt[9]  = mk(4'hA, 32'hFFFF_FFFC, 1, 2, 2'b01, 1, 2, 32'hFFFF_FFFC, 32'h0, 0, 0, 2'b00);
    vt[10] = mk(4'hB, 32'h0000_060C, 1, 2, 2'b10, 1, 2, 32'h60C, 32'h608, 0, 0, 2'b00);

    // Reset values
    repeat (3) @(negedge ACLK);
    chk("rst_awready", axi.AWREADY, 0);
    chk("rst_wready", axi.WREADY, 0);
    chk("rst_bvalid", axi.BVALID, 0);
    chk("rst_bid", axi.BID, 0);
    chk("rst_bresp", axi.BRESP, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("awready_after_rst", axi.AWREADY, 1);

    // W without a queued address must stall
    axi.WVALID = 1'b1; axi.WLAST = 1'b1;
    repeat (3) begin
      @(negedge ACLK);
      chk("w_stall_wready", axi.WREADY, 0);
    end
    axi.WVALID = 1'b0; axi.WLAST = 1'b0;
    chk("w_stall_no_write", wq.size(), 0);

    // Burst table
    for (int i = 0; i < 11; i++) begin
      send_aw(vt[i].id, vt[i].addr, int'(vt[i].len), int'(vt[i].size), vt[i].burst);
      send_w(vt[i].id, int'(vt[i].len) + 1, vt[i].wl);
      recv_b(vt[i].id, vt[i].resp);
      check_writes(vt[i].id, vt[i].nwr, vt[i].ea);
    end

    // Queueing: the first address is popped into the engine, so five pushes
    // leave four entries queued and the FIFO full.
    for (int k = 0; k < 5; k++) send_aw(4'(k + 1), 32'h700 + 32'(16 * k), 0, 2, 2'b01);
    @(negedge ACLK);
    chk("q_full_awready", axi.AWREADY, 0);
    for (int k = 0; k < 5; k++) begin
      logic [3:0][31:0] ea;
      ea = '0;
      ea[0] = 32'h700 + 32'(16 * k);
      send_w(4'(k + 1), 1, 0);
      recv_b(4'(k + 1), 2'b00);
      check_writes(4'(k + 1), 1, ea);
    end

    // B held under back-pressure
    axi.BREADY = 1'b0;
    send_aw(4'h9, 32'h800, 0, 2, 2'b11);
    send_w(4'h9, 1, 0);
    begin
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
        @(negedge ACLK);
        if (axi.BVALID) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) timeout("bp_bvalid");
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge ACLK);
      chk("bp_bvalid", axi.BVALID, 1);
      chk("bp_bid", axi.BID, 4'h9);
      chk("bp_bresp", axi.BRESP, 2'b10);
    end
    axi.BREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("bp_released", axi.BVALID, 0);
    check_writes(4'h9, 0, '0);

    // Reset during DATA: burst dropped, nothing returned
    send_aw(4'h5, 32'h900, 3, 2, 2'b01);
    send_w(4'h5, 2, 3);
    @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    chk("mid_rst_wready", axi.WREADY, 0);
    chk("mid_rst_bvalid", axi.BVALID, 0);
    chk("mid_rst_awready", axi.AWREADY, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    wq.delete();
    repeat (5) begin
      @(negedge ACLK);
      chk("post_rst_bvalid", axi.BVALID, 0);
      chk("post_rst_wready", axi.WREADY, 0);
    end
    begin
      logic [3:0][31:0] ea;
      ea = '0;
      ea[0] = 32'hA00;
      ea[1] = 32'hA04;
      send_aw(4'h6, 32'hA00, 1, 2, 2'b01);
      send_w(4'h6, 2, 1);
      recv_b(4'h6, 2'b00);
      check_writes(4'h6, 2, ea);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
